// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, stability-counter debounce FSM,
// registered clean level plus one-cycle press and release strobes.
module btn_debounce_pulse #(
    parameter int STABLE_CNT = 500000,
    parameter int CNT_W      = 19
) (
    input  logic clk,
    input  logic clr_n,
    input  logic btn_in,
    output logic btn_db,
    output logic btn_pulse,
    output logic btn_rel
);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_r;
    logic             s2_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             btn_db_r;
    logic             btn_pulse_r;
    logic             btn_rel_r;

    // Two-flop synchroniser for the asynchronous raw button level
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= btn_in;
            s2_r <= s1_r;
        end
    end

    // Debounce FSM with stability counter and registered level/strobe outputs
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= IDLE_LO;
            cnt_r       <= CNT_ZERO;
            btn_db_r    <= 1'b0;
            btn_pulse_r <= 1'b0;
            btn_rel_r   <= 1'b0;
        end else begin
            btn_pulse_r <= 1'b0;
            btn_rel_r   <= 1'b0;
            case (state_r)
                IDLE_LO: begin
                    btn_db_r <= 1'b0;
                    cnt_r    <= CNT_ZERO;
                    if (s2_r) begin
                        state_r <= WAIT_HI;
                    end else begin
                        state_r <= IDLE_LO;
                    end
                end
                WAIT_HI: begin
                    if (!s2_r) begin
                        state_r  <= IDLE_LO;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b0;
                    end else if (cnt_r == CNT_LAST) begin
                        // Level and strobe change on the same edge as acceptance
                        state_r     <= IDLE_HI;
                        cnt_r       <= CNT_ZERO;
                        btn_db_r    <= 1'b1;
                        btn_pulse_r <= 1'b1;
                    end else begin
                        state_r  <= WAIT_HI;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b0;
                    end
                end
                IDLE_HI: begin
                    btn_db_r <= 1'b1;
                    cnt_r    <= CNT_ZERO;
                    if (!s2_r) begin
                        state_r <= WAIT_LO;
                    end else begin
                        state_r <= IDLE_HI;
                    end
                end
                WAIT_LO: begin
                    if (s2_r) begin
                        state_r  <= IDLE_HI;
                        cnt_r    <= CNT_ZERO;
                        btn_db_r <= 1'b1;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= IDLE_LO;
                        cnt_r     <= CNT_ZERO;
                        btn_db_r  <= 1'b0;
                        btn_rel_r <= 1'b1;
                    end else begin
                        state_r  <= WAIT_LO;
                        cnt_r    <= cnt_r + CNT_ONE;
                        btn_db_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE_LO;
                    cnt_r    <= CNT_ZERO;
                    btn_db_r <= 1'b0;
                end
            endcase
        end
    end

    assign btn_db    = btn_db_r;
    assign btn_pulse = btn_pulse_r;
    assign btn_rel   = btn_rel_r;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with STABLE_CNT = 4.
module tb_btn_debounce_pulse;

    logic clk;
    logic clr_n;
    logic btn_in;
    logic btn_db;
    logic btn_pulse;
    logic btn_rel;

    int checks;
    int failures;

    btn_debounce_pulse #(
        .STABLE_CNT(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .btn_in(btn_in),
        .btn_db(btn_db),
        .btn_pulse(btn_pulse),
        .btn_rel(btn_rel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs set after a step are seen at the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_n  = 1'b0;
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in;
            step();
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got db/pulse/rel=%b%b%b want 000", i, btn_db, btn_pulse, btn_rel);
            end
        end
        btn_in = 1'b0;
        clr_n  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got db/pulse/rel=%b%b%b want 000", i, btn_db, btn_pulse, btn_rel);
            end
        end
    endtask

    task automatic test_press();
        int pulses;
        pulses = 0;
        btn_in = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (btn_pulse === 1'b1) pulses++;
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== {(n >= 6), (n == 6), 1'b0}) begin
                failures++;
                $display("FAIL press edge=E0+%0d got db/pulse/rel=%b%b%b want %b%b0",
                         n, btn_db, btn_pulse, btn_rel, (n >= 6), (n == 6));
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL press_count got %0d pulses want 1", pulses);
        end
        btn_in = 1'b0;
        for (int n = 0; n < 10; n++) step();
        checks++;
        if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
            failures++;
            $display("FAIL press_cleanup got db/pulse/rel=%b%b%b want 000", btn_db, btn_pulse, btn_rel);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pattern;
        pattern = 6'b011011;
        for (int i = 0; i < 16; i++) begin
            btn_in = (i < 6) ? pattern[5 - i] : 1'b0;
            step();
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
                failures++;
                $display("FAIL bounce cyc=%0d got db/pulse/rel=%b%b%b want 000", i, btn_db, btn_pulse, btn_rel);
            end
        end
    endtask

    task automatic test_settle();
        int pulses;
        pulses = 0;
        btn_in = 1'b1;
        step();
        btn_in = 1'b0;
        step();
        btn_in = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (btn_pulse === 1'b1) pulses++;
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== {(n >= 6), (n == 6), 1'b0}) begin
                failures++;
                $display("FAIL settle edge=E0+%0d got db/pulse/rel=%b%b%b want %b%b0",
                         n, btn_db, btn_pulse, btn_rel, (n >= 6), (n == 6));
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL settle_count got %0d pulses want 1", pulses);
        end
    endtask

    task automatic test_release();
        int rels;
        rels = 0;
        btn_in = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (btn_rel === 1'b1) rels++;
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== {(n < 6), 1'b0, (n == 6)}) begin
                failures++;
                $display("FAIL release edge=E0+%0d got db/pulse/rel=%b%b%b want %b0%b",
                         n, btn_db, btn_pulse, btn_rel, (n < 6), (n == 6));
            end
        end
        checks++;
        if (rels != 1) begin
            failures++;
            $display("FAIL release_count got %0d strobes want 1", rels);
        end
    endtask

    task automatic test_reset_mid();
        btn_in = 1'b1;
        for (int n = 0; n < 5; n++) step();
        clr_n = 1'b0;
        #1;
        checks++;
        if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_async got db/pulse/rel=%b%b%b want 000", btn_db, btn_pulse, btn_rel);
        end
        step();
        step();
        clr_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== {(n >= 6), (n == 6), 1'b0}) begin
                failures++;
                $display("FAIL reset_mid_restart edge=E0+%0d got db/pulse/rel=%b%b%b want %b%b0",
                         n, btn_db, btn_pulse, btn_rel, (n >= 6), (n == 6));
            end
        end
    endtask

    task automatic test_async_clear_pressed();
        checks++;
        if (btn_db !== 1'b1) begin
            failures++;
            $display("FAIL clear_pressed_pre got db=%b want 1", btn_db);
        end
        #2;
        clr_n = 1'b0;
        #1;
        checks++;
        if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
            failures++;
            $display("FAIL clear_pressed_async got db/pulse/rel=%b%b%b want 000", btn_db, btn_pulse, btn_rel);
        end
        btn_in = 1'b0;
        step();
        clr_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            checks++;
            if ({btn_db, btn_pulse, btn_rel} !== 3'b000) begin
                failures++;
                $display("FAIL clear_pressed_after cyc=%0d got db/pulse/rel=%b%b%b want 000",
                         n, btn_db, btn_pulse, btn_rel);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr_n    = 1'b0;
        btn_in   = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_settle();
        test_release();
        test_reset_mid();
        test_async_clear_pressed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
